mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single byte-wide slave memory port (s_cs/s_write/s_addr/s_wdata ↔ m_rdata/m_ready/m_error) between NUM_REQ requesters, for example the APB controller and a scrub/DMA engine.
- Uses round-robin arbitration with burst tenure, so a 16-beat 128-bit transfer from one requester is never interleaved with another requester's beats.
- Sits between the requesters' memory-side outputs and the memory.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, memory byte address width (line address + 4-bit beat index).
- DATA_W, 8, memory data width.
- BURST_LEN, 16, maximum completed beats per tenure (fairness cap).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- r_cs  in  NUM_REQ  per-requester access request.
- r_lock  in  NUM_REQ  requester holds the port across beats (burst in progress).
- r_write  in  NUM_REQ  1 = write, 0 = read.
- r_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- r_wdata  in  NUM_REQ*DATA_W  packed write data.
- r_rdata  out  DATA_W  read data, broadcast to all requesters.
- r_ready  out  NUM_REQ  beat-complete strobe to the owner only.
- r_error  out  NUM_REQ  error for the completing beat, owner only.
- grant  out  NUM_REQ  one-hot current owner, registered.
- s_cs  out  1  memory chip select.
- s_write  out  1  memory write enable.
- s_addr  out  ADDR_W  memory address.
- s_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data.
- m_ready  in  1  memory beat accepted/complete.
- m_error  in  1  memory error for the current beat.

Behaviour:
- Reset (PRESET high at an edge):
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
  - s_cs=0, s_write=0, s_addr=0, s_wdata=0.
  - r_ready=0, r_error=0, r_rdata=0.
  - Applies mid-burst too: the tenure is dropped and the memory sees s_cs=0 from the next cycle.
- States:
  - IDLE: no owner.
  - OWN: grant one-hot, beats flowing.
  - RELEASE: one-cycle gap, s_cs=0; rr_ptr = owner+1 mod NUM_REQ.
- IDLE → OWN:
  - Taken when any r_cs is high.
  - Winner is the first requester with r_cs=1 searching from rr_ptr upward with wrap.
  - grant is registered at that edge; s_cs is asserted in the following cycle (1-cycle grant latency).
- In OWN, the memory-side outputs are combinational muxes of the owner's inputs:
  - s_cs = r_cs[owner]
  - s_write = r_write[owner]
  - s_addr = r_addr[owner]
  - s_wdata = r_wdata[owner]
- Beat completion (s_cs & m_ready in a cycle):
  - r_ready[owner]=1 and r_error[owner]=m_error, same cycle.
  - r_rdata = m_rdata, same cycle.
  - beat_cnt increments.
  - Non-owners' r_ready and r_error remain 0.
- OWN → RELEASE, either condition:
  - owner has r_cs=0 and r_lock=0; or
  - beat_cnt reaches BURST_LEN on a completing beat, with r_lock ignored (a hard cap).
- beat_cnt clears on every entry into OWN.
- RELEASE → OWN if any r_cs is high (round-robin from the new rr_ptr), else → IDLE.
- A sole requester can re-win immediately after RELEASE; the gap cycle is mandatory.
- Simultaneous requests from all requesters are served in strict rotation; no requester waits more than NUM_REQ-1 tenures.
- Owner holding r_lock=1 with r_cs=0: the tenure is kept, s_cs=0 and no beats occur.
- m_error does not end the tenure; it is reported only.
- m_ready while s_cs=0 is ignored.
- r_cs of a non-owner has no effect on the memory outputs.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_t enum {IDLE, OWN, RELEASE}.
  - BURST_LEN_DEF=16.
  - Function onehot2idx.
- One sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_REQ], ptr.
  - Outputs: gnt one-hot, valid.
  - Instantiated once; used both from IDLE and from RELEASE.

Test Plan:
- Reset mid-burst: requester 0 locked at beat 5, assert PRESET for 1 cycle → next cycle grant=0 and s_cs=0; state IDLE with rr_ptr=0; a new r_cs[1] is granted 1 cycle later.
- Single requester read: r_cs[0]=1, r_lock[0]=1 for 16 beats, m_ready=1, m_rdata=beat index → grant=01 one cycle after the request; r_ready[0] high for 16 cycles with r_rdata 0x00..0x0F; RELEASE follows.
- Contention: r_cs[0] and r_cs[1] high together, each locking for 16 beats → order is req0 then req1 then req0, with a single s_cs=0 cycle between tenures; r_ready[1] is never high during req0's tenure.
- Fairness cap: requester 1 holds r_lock=1 for 20 beats with requester 0 waiting → forced RELEASE after the 16th completed beat; requester 0 is granted next.
- Wait states and error: m_ready toggles 0,1,0,1 and m_error=1 on beat 3 → beat_cnt advances only on m_ready=1; r_error[owner]=1 only on beat 3's completion cycle; the tenure continues.
- Idle lock: owner has r_cs=0, r_lock=1 for 4 cycles → grant held, s_cs=0, no r_ready pulses; beats resume when r_cs returns to 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, OWN, RELEASE)
//   BURST_LEN_DEF : default fairness cap in completed beats per tenure
//   MAX_REQ       : largest supported requester count
//   onehot2idx    : converts a one-hot grant vector into a requester index
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int BURST_LEN_DEF = 16;
  localparam int MAX_REQ       = 8;

  // Index of the set bit; returns 0 for an all-zero vector.
  function automatic int onehot2idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : per-requester request vector
//   ptr   : index of the highest-priority requester for this pick
//   gnt   : one-hot winner (all zero when no request)
//   valid : at least one request present
// The search starts at ptr and walks upward, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // One extra bit so ptr + i cannot overflow before the wrap correction.
  logic [IDX_W:0] cand;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!valid && req[cand[IDX_W-1:0]]) begin
        gnt[cand[IDX_W-1:0]] = 1'b1;
        valid                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between NUM_REQ
// requesters, with burst tenure so one requester's beats are never
// interleaved with another's.
//
// Ports:
//   PCLK, PRESET          : clock, synchronous active-high reset
//   r_cs/r_lock/r_write   : per-requester request, tenure hold, direction
//   r_addr/r_wdata        : packed per-requester address / write data
//   r_rdata               : read data broadcast (valid with r_ready)
//   r_ready/r_error       : beat-complete strobe / beat error, owner only
//   grant                 : registered one-hot owner
//   s_cs/s_write/s_addr/s_wdata : memory-side request
//   m_rdata/m_ready/m_error     : memory-side response
//   dbg_state/dbg_rr_ptr/dbg_beat_cnt : FSM state, priority pointer, beat count
//
// Handshake: a beat is offered when s_cs is high and completes in any cycle
// where m_ready is also high; in that same cycle the owner sees r_ready (with
// r_error and r_rdata) and presents its next beat, or drops r_cs, from the
// following cycle. m_ready while s_cs is low means nothing.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            r_cs,
  input  logic [NUM_REQ-1:0]            r_lock,
  input  logic [NUM_REQ-1:0]            r_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     r_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     r_wdata,
  output logic [DATA_W-1:0]             r_rdata,
  output logic [NUM_REQ-1:0]            r_ready,
  output logic [NUM_REQ-1:0]            r_error,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          s_cs,
  output logic                          s_write,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic                          m_ready,
  input  logic                          m_error,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(NUM_REQ)-1:0]    dbg_rr_ptr,
  output logic [$clog2(BURST_LEN+1)-1:0] dbg_beat_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_t         state, state_nx;
  logic [NUM_REQ-1:0] grant_nx;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nx;

  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_valid;
  logic [MAX_REQ-1:0] grant_wide;
  logic [IDX_W-1:0]   owner_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic               owner_cs;
  logic               owner_lock;
  logic               beat_done;
  logic               cap_hit;

  // Single picker serves both the IDLE and RELEASE decisions; rr_ptr has
  // already moved past the previous owner by the time RELEASE is entered.
  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (r_cs),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  assign grant_wide = MAX_REQ'(grant);
  assign owner_idx  = IDX_W'(onehot2idx(grant_wide));
  assign next_ptr   = (owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx + IDX_W'(1);

  // grant is zero outside OWN, so these reductions are inert there.
  assign owner_cs   = |(r_cs & grant);
  assign owner_lock = |(r_lock & grant);
  assign beat_done  = (state == OWN) && owner_cs && m_ready;
  // The cap ignores r_lock: the BURST_LEN-th completed beat always ends tenure.
  assign cap_hit    = beat_done && (beat_cnt == CNT_W'(BURST_LEN - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      rr_ptr   <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    rr_ptr_nx   = rr_ptr;
    beat_cnt_nx = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nx    = OWN;
          grant_nx    = pick_gnt;
          beat_cnt_nx = '0;
        end
      end
      OWN: begin
        if (beat_done) beat_cnt_nx = beat_cnt + CNT_W'(1);
        if (cap_hit || (!owner_cs && !owner_lock)) begin
          state_nx  = RELEASE;
          grant_nx  = '0;
          rr_ptr_nx = next_ptr;
        end
      end
      RELEASE: begin
        // Mandatory one-cycle gap; a sole requester may win straight back.
        if (pick_valid) begin
          state_nx    = OWN;
          grant_nx    = pick_gnt;
          beat_cnt_nx = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  // Memory-side mux: AND-OR over the one-hot grant, so non-owners never
  // reach the memory outputs.
  always_comb begin
    s_cs    = 1'b0;
    s_write = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    r_ready = '0;
    r_error = '0;
    r_rdata = '0;
    if (state == OWN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          s_cs    = r_cs[i];
          s_write = r_write[i];
          s_addr  = r_addr[i*ADDR_W +: ADDR_W];
          s_wdata = r_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
    if (beat_done) begin
      r_ready = grant;
      r_rdata = m_rdata;
      if (m_error) r_error = grant;
    end
  end

  assign dbg_state    = state;
  assign dbg_rr_ptr   = rr_ptr;
  assign dbg_beat_cnt = beat_cnt;

endmodule
